// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//
// Multi-channel input conditioner for pad-level signals such as buttons, straps
// and external status lines. It replaces the ad-hoc synchronizer-plus-edge-
// detect logic between the pads and the control FSMs. Each channel has three
// parts:
//   1. a STAGES-deep flop chain that brings the asynchronous input into clk,
//   2. a debounce filter whose length is programmable at run time, shared by
//      all channels but with an independent counter per channel,
//   3. registered rise/fall event pulses, plus a summary any_event flag.
//
// Ports
//   clk           system clock
//   rst_n         synchronous, active-low reset
//   async_in      [CHANNELS]  asynchronous inputs, no timing relation to clk
//   debounce_len  [CNT_BITS]  quasi-static filter length, synchronous to clk
//   sync_out      [CHANNELS]  raw synchronized value (last chain stage)
//   level_out     [CHANNELS]  debounced level
//   rise_pulse    [CHANNELS]  one-cycle pulse when level_out goes 0->1
//   fall_pulse    [CHANNELS]  one-cycle pulse when level_out goes 1->0
//   any_event     registered OR of all rise/fall pulses, same cycle as them
//
// Timing
//   An async_in change sampled at edge k appears on sync_out after edge
//   k+STAGES-1. It reaches level_out, together with the matching pulse,
//   after edge k+STAGES+debounce_len.
// -----------------------------------------------------------------------------
module sync_debounce #(
  parameter int                  CHANNELS    = 4,
  parameter int                  STAGES      = 2,
  parameter int                  CNT_BITS    = 4,
  parameter logic [CHANNELS-1:0] RESET_LEVEL = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [CNT_BITS-1:0] debounce_len,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_event
);

  // A single flop does not give metastability enough time to resolve, so a
  // chain shorter than two stages is rejected at elaboration.
  generate
    if (STAGES < 2) begin : g_stages_check
      $error("sync_debounce: STAGES must be >= 2");
    end
  endgenerate

  // Saturating increment. The threshold compare already stops the count at
  // debounce_len, so this is a second guard that keeps the counter from
  // wrapping even if that compare logic is changed later.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronizer chain: stage 0 samples the pad and each later stage copies
  // the one before it. sync_out is taken straight from the last flop, so no
  // combinational path runs from async_in to any output.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RESET_LEVEL;
      end
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce filter and event generation
  // ---------------------------------------------------------------------------
  logic [CNT_BITS-1:0] cnt_q [CHANNELS];
  logic [CNT_BITS-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic                any_q, any_d;

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
    end

    for (int c = 0; c < CHANNELS; c++) begin
      if (sync_out[c] == level_q[c]) begin
        // Agreement, including a glitch that returns early: restart the count.
        cnt_d[c] = '0;
      end else if (cnt_q[c] >= debounce_len) begin
        // Using >= rather than == means a count still ends if debounce_len
        // is lowered below it partway through.
        level_d[c] = sync_out[c];
        cnt_d[c]   = '0;
        rise_d[c]  = sync_out[c];
        fall_d[c]  = ~sync_out[c];
      end else begin
        cnt_d[c] = sat_inc(cnt_q[c]);
      end
    end

    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= RESET_LEVEL;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_event  = any_q;

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce
//
// Testbench for sync_debounce (CHANNELS=4, STAGES=2, CNT_BITS=4, RESET_LEVEL=0).
// A behavioural model follows every clock edge. It treats sync_out as
// async_in delayed by a queue, and treats the filter as "a disagreement streak
// must outlast debounce_len". Directed scenarios, whose expected timings are
// written out explicitly, run first, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

  localparam int         CH = 4;
  localparam int         ST = 2;
  localparam int         CB = 4;
  localparam logic [3:0] RL = 4'b0000;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] a_in;
  logic [CB-1:0] len;
  logic [CH-1:0] sync_out, level_out, rise_pulse, fall_pulse;
  logic          any_event;

  sync_debounce #(
    .CHANNELS   (CH),
    .STAGES     (ST),
    .CNT_BITS   (CB),
    .RESET_LEVEL(RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .async_in    (a_in),
    .debounce_len(len),
    .sync_out    (sync_out),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .any_event   (any_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [CH-1:0] hist[$];            // async_in samples still in flight
  logic [CH-1:0] m_sync, m_level, m_rise, m_fall;
  logic          m_any;
  int            m_streak[CH];       // consecutive disagreeing edges so far

  task automatic model_edge();
    logic [CH-1:0] s_pre;
    if (!rst_n) begin
      hist = {};
      repeat (ST - 1) hist.push_back(RL);
      m_sync  = RL;
      m_level = RL;
      m_rise  = '0;
      m_fall  = '0;
      m_any   = 1'b0;
      for (int c = 0; c < CH; c++) m_streak[c] = 0;
    end else begin
      s_pre  = m_sync;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        if (s_pre[c] == m_level[c]) begin
          m_streak[c] = 0;
        end else if (m_streak[c] >= int'(len)) begin
          m_level[c]  = s_pre[c];
          m_streak[c] = 0;
          if (s_pre[c]) m_rise[c] = 1'b1;
          else          m_fall[c] = 1'b1;
        end else begin
          m_streak[c]++;
        end
      end
      m_any = |(m_rise | m_fall);
      hist.push_back(a_in);
      m_sync = hist.pop_front();
    end
  endtask

  // One clock edge: advance the model, then sample the DUT 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_sync",  sync_out,   m_sync);
    check("model_level", level_out,  m_level);
    check("model_rise",  rise_pulse, m_rise);
    check("model_fall",  fall_pulse, m_fall);
    check("model_any",   any_event,  m_any);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    a_in  = '0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  int p;

  initial begin
    rst_n = 1'b0;
    a_in  = 4'hF;
    len   = 4'd3;

    // Reset with inputs high: every output stays at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_sync",  sync_out,   4'h0);
      check("rst_level", level_out,  4'h0);
      check("rst_rise",  rise_pulse, 4'h0);
      check("rst_fall",  fall_pulse, 4'h0);
      check("rst_any",   any_event,  1'b0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("rel_sync",  sync_out,   (i >= 2) ? 4'hF : 4'h0);
      check("rel_level", level_out,  (i >= 6) ? 4'hF : 4'h0);
      check("rel_rise",  rise_pulse, (i == 6) ? 4'hF : 4'h0);
      check("rel_any",   any_event,  i == 6);
    end

    // Clean rising edge on channel 0 with debounce_len=3.
    do_reset(2);
    len = 4'd3;
    repeat (2) tick();
    a_in = 4'b0001;
    for (int j = 0; j <= 7; j++) begin
      tick();
      check("clean_sync0",  sync_out[0],   j >= 1);
      check("clean_level0", level_out[0],  j >= 5);
      check("clean_rise0",  rise_pulse[0], j == 5);
      check("clean_any",    any_event,     j == 5);
    end

    // A 3-cycle glitch on channel 1 is rejected.
    a_in = 4'b0011;
    for (int j = 0; j <= 8; j++) begin
      tick();
      if (j == 2) a_in = 4'b0001;
      check("glitch_sync1",  sync_out[1],   (j >= 1) && (j <= 3));
      check("glitch_level1", level_out[1],  1'b0);
      check("glitch_rise1",  rise_pulse[1], 1'b0);
      check("glitch_fall1",  fall_pulse[1], 1'b0);
    end

    // A 4-cycle pulse passes, then falls four edges after sync_out drops.
    a_in = 4'b0011;
    for (int j = 0; j <= 10; j++) begin
      tick();
      if (j == 3) a_in = 4'b0001;
      check("pulse4_level1", level_out[1],  (j >= 5) && (j <= 8));
      check("pulse4_rise1",  rise_pulse[1], j == 5);
      check("pulse4_fall1",  fall_pulse[1], j == 9);
    end

    // Several channels change at once with debounce_len=0.
    do_reset(2);
    len = 4'd0;
    repeat (2) tick();
    a_in = 4'b1010;
    for (int j = 0; j <= 6; j++) begin
      tick();
      if (j == 1) a_in = 4'b0101;
      check("multi_rise", rise_pulse, (j == 2) ? 4'b1010 : (j == 4) ? 4'b0101 : 4'b0000);
      check("multi_fall", fall_pulse, (j == 4) ? 4'b1010 : 4'b0000);
      check("multi_any",  any_event,  (j == 2) || (j == 4));
    end

    // Lowering the threshold partway through ends the count at once.
    do_reset(2);
    len = 4'd15;
    repeat (2) tick();
    a_in = 4'b0001;
    for (int j = 0; j <= 6; j++) begin
      tick();
      check("lower_hold0", level_out[0], 1'b0);
    end
    len = 4'd2;
    tick();
    check("lower_level0", level_out[0],  1'b1);
    check("lower_rise0",  rise_pulse[0], 1'b1);

    // Raising the threshold partway through extends the count (11 edges).
    len  = 4'd2;
    a_in = 4'b0011;
    for (int j = 0; j <= 13; j++) begin
      tick();
      if (j == 2) len = 4'd10;
      check("raise_level1", level_out[1],  j >= 12);
      check("raise_rise1",  rise_pulse[1], j == 12);
    end

    // Reset partway through a count discards it; full latency afterwards.
    len  = 4'd3;
    a_in = 4'b0111;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_level", level_out,  RL);
    check("midrst_sync",  sync_out,   RL);
    check("midrst_rise",  rise_pulse, 4'h0);
    rst_n = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      tick();
      check("midrst_lvl",   level_out,  (j >= 5) ? 4'b0111 : 4'b0000);
      check("midrst_rise2", rise_pulse, (j == 5) ? 4'b0111 : 4'b0000);
    end

    // Randomized traffic; the model checks every edge.
    p = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) p = $urandom_range(2, 16);
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 63) == 0) len = CB'($urandom_range(0, 6));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, p - 1) == 0) a_in[c] = ~a_in[c];
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
